// File: rtl/tv_pkg.sv
// Shared constants and types for the TV-in capture path.
package tv_pkg;

  localparam int unsigned TV_IN_WIDTH    = 720;
  localparam int unsigned TV_OUT_WIDTH   = 640;
  localparam int unsigned TV_DROP_PERIOD = 9;

  localparam int unsigned TV_X_W  = 10;
  localparam int unsigned TV_PH_W = 4;
  localparam int unsigned TV_C_W  = 8;

  localparam logic [TV_C_W-1:0] C_NEUTRAL = 8'h80;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } hs_state_t;

  // One 4:2:2 sample: luma in the upper byte, alternating Cb/Cr in the lower.
  typedef struct packed {
    logic [TV_C_W-1:0] y;
    logic [TV_C_W-1:0] c;
  } ycc_t;

endpackage

// File: rtl/tv_hscale_720to640.sv
// 720->640 horizontal decimator: drops every ninth sample, re-pairs chroma
// so Cb/Cr alternation follows the output index, and flags broken lines.
module tv_hscale_720to640
  import tv_pkg::*;
(
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [15:0]         iYCbCr,
  input  logic [TV_X_W-1:0]   iX,
  input  logic                iDVAL,
  output logic [15:0]         oYCbCr,
  output logic [TV_X_W-1:0]   oX,
  output logic                oDVAL,
  output logic                oEOL,
  output logic                oLINE_ERR,
  output logic [TV_X_W-1:0]   oLAST_CNT
);

  localparam logic [TV_PH_W-1:0] PH_LAST  = TV_PH_W'(TV_DROP_PERIOD - 1);
  localparam logic [TV_X_W-1:0]  OUT_LAST = TV_X_W'(TV_OUT_WIDTH - 1);
  localparam logic [TV_X_W-1:0]  OUT_CNT  = TV_X_W'(TV_OUT_WIDTH);

  hs_state_t           state, state_nx;
  logic [TV_PH_W-1:0]  phase, phase_nx;
  logic [TV_X_W-1:0]   prev_x, prev_x_nx;
  logic [TV_X_W-1:0]   out_cnt, out_cnt_nx;
  logic [TV_C_W-1:0]   hold_cb, hold_cb_nx;
  logic [TV_C_W-1:0]   hold_cr, hold_cr_nx;
  ycc_t                in_s;
  ycc_t                ycc_nx;
  logic [TV_X_W-1:0]   x_nx;
  logic                dval_nx, eol_nx, err_nx;
  logic [TV_X_W-1:0]   last_nx;

  assign in_s = ycc_t'(iYCbCr);

  // State, counters, chroma hold and registered outputs.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      phase     <= '0;
      prev_x    <= '0;
      out_cnt   <= '0;
      hold_cb   <= C_NEUTRAL;
      hold_cr   <= C_NEUTRAL;
      oYCbCr    <= '0;
      oX        <= '0;
      oDVAL     <= 1'b0;
      oEOL      <= 1'b0;
      oLINE_ERR <= 1'b0;
      oLAST_CNT <= '0;
    end else begin
      state     <= state_nx;
      phase     <= phase_nx;
      prev_x    <= prev_x_nx;
      out_cnt   <= out_cnt_nx;
      hold_cb   <= hold_cb_nx;
      hold_cr   <= hold_cr_nx;
      oYCbCr    <= 16'(ycc_nx);
      oX        <= x_nx;
      oDVAL     <= dval_nx;
      oEOL      <= eol_nx;
      oLINE_ERR <= err_nx;
      oLAST_CNT <= last_nx;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nx   = state;
    phase_nx   = phase;
    prev_x_nx  = prev_x;
    out_cnt_nx = out_cnt;
    hold_cb_nx = hold_cb;
    hold_cr_nx = hold_cr;
    ycc_nx     = ycc_t'(oYCbCr);
    x_nx       = oX;
    dval_nx    = 1'b0;
    eol_nx     = 1'b0;
    err_nx     = 1'b0;
    last_nx    = oLAST_CNT;

    if (iDVAL) begin
      // Chroma hold tracks every valid sample, dropped ones included.
      if (iX[0]) hold_cr_nx = in_s.c;
      else       hold_cb_nx = in_s.c;

      unique case (state)
        IDLE, DONE: begin
          if (iX == '0) begin
            phase_nx   = TV_PH_W'(1);
            out_cnt_nx = '0;
            prev_x_nx  = '0;
            state_nx   = ACTIVE;
          end
        end
        ACTIVE: begin
          if (iX == '0) begin
            err_nx     = 1'b1;
            last_nx    = out_cnt;
            phase_nx   = TV_PH_W'(1);
            out_cnt_nx = '0;
            prev_x_nx  = '0;
          end else if (iX != prev_x + TV_X_W'(1)) begin
            err_nx   = 1'b1;
            last_nx  = out_cnt;
            state_nx = IDLE;
          end else begin
            prev_x_nx = iX;
            phase_nx  = (phase == PH_LAST) ? '0 : phase + TV_PH_W'(1);
            if (phase != '0) begin
              dval_nx  = 1'b1;
              ycc_nx.y = in_s.y;
              ycc_nx.c = out_cnt[0] ? hold_cr_nx : hold_cb_nx;
              x_nx     = out_cnt;
              if (out_cnt == OUT_LAST) begin
                eol_nx   = 1'b1;
                last_nx  = OUT_CNT;
                state_nx = DONE;
              end else begin
                out_cnt_nx = out_cnt + TV_X_W'(1);
              end
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tv_hscale_720to640.sv
// Directed bench for the 720->640 decimator: full lines, gapped input,
// chroma pairing, aborted/discontinuous lines and mid-line reset.
module tb_tv_hscale_720to640;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [15:0] iYCbCr;
  logic [9:0]  iX;
  logic        iDVAL;
  logic [15:0] oYCbCr;
  logic [9:0]  oX;
  logic        oDVAL;
  logic        oEOL;
  logic        oLINE_ERR;
  logic [9:0]  oLAST_CNT;

  tv_hscale_720to640 dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iYCbCr    (iYCbCr),
    .iX        (iX),
    .iDVAL     (iDVAL),
    .oYCbCr    (oYCbCr),
    .oX        (oX),
    .oDVAL     (oDVAL),
    .oEOL      (oEOL),
    .oLINE_ERR (oLINE_ERR),
    .oLAST_CNT (oLAST_CNT)
  );

  always #5 iCLK = ~iCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Output capture.
  logic [9:0]  q_x[$];
  logic [15:0] q_d[$];
  logic        q_e[$];
  int          q_t[$];
  int          err_cnt = 0;
  int          eol_cnt = 0;
  int          cyc = 0;

  always @(posedge iCLK) cyc++;

  always @(negedge iCLK) begin
    if (oDVAL === 1'b1) begin
      q_x.push_back(oX);
      q_d.push_back(oYCbCr);
      q_e.push_back(oEOL);
      q_t.push_back(cyc);
    end
    if (oLINE_ERR === 1'b1) err_cnt++;
    if (oEOL === 1'b1) eol_cnt++;
  end

  task automatic clear_capture();
    q_x.delete();
    q_d.delete();
    q_e.delete();
    q_t.delete();
    err_cnt = 0;
    eol_cnt = 0;
  endtask

  // cmode 0: C = iX[7:0]; cmode 1: C = 8'h10 at even iX, 8'h20 at odd iX.
  task automatic send(input int x, input int cmode, input bit gap);
    logic [7:0] c;
    logic [9:0] xv;
    xv = 10'(x);
    if (cmode == 0) c = xv[7:0];
    else            c = xv[0] ? 8'h20 : 8'h10;
    @(posedge iCLK);
    #1;
    iDVAL  = 1'b1;
    iX     = xv;
    iYCbCr = {xv[7:0], c};
    if (gap) begin
      @(posedge iCLK);
      #1;
      iDVAL = 1'b0;
    end
  endtask

  task automatic send_range(input int lo, input int hi, input int cmode, input bit gap);
    for (int x = lo; x <= hi; x++) send(x, cmode, gap);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iCLK);
      #1;
      iDVAL = 1'b0;
    end
  endtask

  // Output k comes from input x = k + k/8 + 1 (every ninth input is dropped).
  task automatic check_out(input string tag, input int n, input int cmode);
    int m;
    int x;
    logic [7:0] ec;
    logic [7:0] xb;
    check({tag, "_count"}, 32'(q_x.size()), 32'(n));
    m = (q_x.size() < n) ? q_x.size() : n;
    for (int k = 0; k < m; k++) begin
      x  = k + k / 8 + 1;
      xb = 8'(x);
      if (cmode == 0) begin
        if ((k % 2) == (x % 2)) ec = xb;
        else                    ec = 8'(x - 1);
      end else begin
        ec = (k % 2 == 0) ? 8'h10 : 8'h20;
      end
      check($sformatf("%s_ox[%0d]", tag, k), 32'(q_x[k]), 32'(k));
      check($sformatf("%s_y[%0d]", tag, k), 32'(q_d[k][15:8]), 32'(xb));
      check($sformatf("%s_c[%0d]", tag, k), 32'(q_d[k][7:0]), 32'(ec));
      check($sformatf("%s_eol[%0d]", tag, k), 32'(q_e[k]), 32'(k == 639));
    end
  endtask

  initial begin
    iRST   = 1'b1;
    iDVAL  = 1'b0;
    iX     = '0;
    iYCbCr = '0;
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_ycc",  32'(oYCbCr), 0);
    check("rst_x",    32'(oX), 0);
    check("rst_dval", 32'(oDVAL), 0);
    check("rst_eol",  32'(oEOL), 0);
    check("rst_err",  32'(oLINE_ERR), 0);
    check("rst_last", 32'(oLAST_CNT), 0);
    iRST = 1'b0;
    idle(2);

    // Full continuous line.
    clear_capture();
    send_range(0, 719, 0, 1'b0);
    idle(4);
    check_out("t1", 640, 0);
    check("t1_last", 32'(oLAST_CNT), 640);
    check("t1_err", 32'(err_cnt), 0);
    check("t1_eolcnt", 32'(eol_cnt), 1);

    // Same line with iDVAL low every other cycle.
    clear_capture();
    send_range(0, 719, 0, 1'b1);
    idle(4);
    check_out("t2", 640, 0);
    if (q_t.size() >= 9) begin
      check("t2_gap01", 32'(q_t[1] - q_t[0]), 2);
      check("t2_gap78", 32'(q_t[8] - q_t[7]), 4);
    end
    check("t2_err", 32'(err_cnt), 0);

    // Chroma re-pairing across drops.
    clear_capture();
    send_range(0, 719, 1, 1'b0);
    idle(4);
    check_out("t3", 640, 1);
    check("t3_last", 32'(oLAST_CNT), 640);

    // Line aborted at iX=300 by a fresh iX=0.
    clear_capture();
    send_range(0, 299, 0, 1'b0);
    idle(4);
    check_out("t4a", 266, 0);
    check("t4a_err", 32'(err_cnt), 0);
    check("t4a_last", 32'(oLAST_CNT), 640);
    clear_capture();
    send(0, 0, 1'b0);
    idle(2);
    check("t4_err", 32'(err_cnt), 1);
    check("t4_last", 32'(oLAST_CNT), 266);
    send_range(1, 719, 0, 1'b0);
    idle(4);
    check_out("t4b", 640, 0);
    check("t4b_err", 32'(err_cnt), 1);
    check("t4b_last", 32'(oLAST_CNT), 640);

    // Discontinuity: iX jumps from 99 to 150.
    clear_capture();
    send_range(0, 99, 0, 1'b0);
    send_range(150, 719, 0, 1'b0);
    idle(4);
    check_out("t5", 88, 0);
    check("t5_err", 32'(err_cnt), 1);
    check("t5_last", 32'(oLAST_CNT), 88);
    clear_capture();
    send_range(0, 719, 0, 1'b0);
    idle(4);
    check_out("t5b", 640, 0);
    check("t5b_err", 32'(err_cnt), 0);

    // Reset asserted mid-line at iX=400, released mid-line.
    send_range(0, 400, 0, 1'b0);
    @(posedge iCLK);
    #2;
    iRST = 1'b1;
    #1;
    check("t6_ycc",  32'(oYCbCr), 0);
    check("t6_x",    32'(oX), 0);
    check("t6_dval", 32'(oDVAL), 0);
    check("t6_last", 32'(oLAST_CNT), 0);
    clear_capture();
    send(401, 0, 1'b0);
    send(402, 0, 1'b0);
    #2;
    iRST = 1'b0;
    send_range(403, 719, 0, 1'b0);
    idle(4);
    check("t6_tail_count", 32'(q_x.size()), 0);
    check("t6_tail_err", 32'(err_cnt), 0);
    clear_capture();
    send_range(0, 719, 0, 1'b0);
    idle(4);
    check_out("t6b", 640, 0);
    check("t6b_last", 32'(oLAST_CNT), 640);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
